sif_bridge: RTL and testbench

Parametrised successor to the single-transfer SIF path. Accepts X-side write/read requests, queues them in order in a DEPTH-entry request FIFO, and issues them to the W side with backpressure (wa_ready). It forwards W-side read data back to X, with a read timeout.
Sits between the X-side master and the W-side slave. It is the next-generation DUT behind the existing SIF clocking-block bench.

---
 rtl/sif_bridge.sv | 145 ++++++++++++++
 tb/tb_sif_bridge.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sif_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sif_bridge: X-to-W request bridge, in-order request FIFO, read timeout    |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module sif_bridge #(
  parameter int            AW       = 16,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 4,
  parameter int            TIMEOUT  = 16,
  parameter logic [DW-1:0] ERR_DATA = '1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [AW-1:0]              xa_addr,
  input  logic [DW-1:0]              xa_data_wr,
  input  logic                       xa_wr_s,
  input  logic                       xa_rd_s,
  output logic                       xa_ready,
  output logic [DW-1:0]              xa_data_rd,
  output logic                       xa_rd_valid,
  output logic                       xa_rd_err,
  output logic [AW-1:0]              wa_addr,
  output logic [DW-1:0]              wa_data_wr,
  output logic                       wa_wr_s,
  output logic                       wa_rd_s,
  input  logic                       wa_ready,
  input  logic [DW-1:0]              wa_data_rd,
  input  logic                       wa_rd_valid,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = 1 + AW + DW;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_next;
  logic [TW-1:0] timer;
  state_t        state;

  logic          push;
  logic          pop;
  logic          head_is_rd;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;

  // A simultaneous write+read strobe is stored as a write.
  assign push = (xa_wr_s | xa_rd_s) & xa_ready;
  assign pop  = (state == IDLE) && (level != '0) && wa_ready;

  assign {head_is_rd, head_addr, head_data} = mem[rd_ptr];
  assign fifo_level = level;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {xa_rd_s & ~xa_wr_s, xa_addr, xa_data_wr};
    end
  end

  // xa_ready is registered from the next level so a push can never hit a full FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      xa_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level    <= level_next;
      xa_ready <= (level_next < LW'(DEPTH));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      timer       <= '0;
      wa_addr     <= '0;
      wa_data_wr  <= '0;
      wa_wr_s     <= 1'b0;
      wa_rd_s     <= 1'b0;
      xa_data_rd  <= '0;
      xa_rd_valid <= 1'b0;
      xa_rd_err   <= 1'b0;
    end else begin
      wa_wr_s     <= 1'b0;
      wa_rd_s     <= 1'b0;
      xa_rd_valid <= 1'b0;
      xa_rd_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            wa_addr    <= head_addr;
            wa_data_wr <= head_data;
            if (head_is_rd) begin
              wa_rd_s <= 1'b1;
              timer   <= '0;
              state   <= WAIT_RD;
            end else begin
              wa_wr_s <= 1'b1;
            end
          end
        end
        WAIT_RD: begin
          // Returned data takes priority over an expiring timer.
          if (wa_rd_valid) begin
            xa_data_rd  <= wa_data_rd;
            xa_rd_valid <= 1'b1;
            state       <= IDLE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            xa_data_rd  <= ERR_DATA;
            xa_rd_valid <= 1'b1;
            xa_rd_err   <= 1'b1;
            state       <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sif_bridge.sv
`default_nettype none
// tb_sif_bridge: scoreboard bench for sif_bridge with a configurable W-side responder.
module tb_sif_bridge;
  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;
  localparam int LW      = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] xa_addr = '0;
  logic [DW-1:0] xa_data_wr = '0;
  logic          xa_wr_s = 1'b0;
  logic          xa_rd_s = 1'b0;
  logic          xa_ready;
  logic [DW-1:0] xa_data_rd;
  logic          xa_rd_valid;
  logic          xa_rd_err;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data_wr;
  logic          wa_wr_s;
  logic          wa_rd_s;
  logic          wa_ready = 1'b1;
  logic [DW-1:0] wa_data_rd = 16'hDEAD;
  logic          wa_rd_valid = 1'b0;
  logic [LW-1:0] fifo_level;

  sif_bridge #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ERR_DATA({DW{1'b1}})
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .xa_addr(xa_addr), .xa_data_wr(xa_data_wr), .xa_wr_s(xa_wr_s), .xa_rd_s(xa_rd_s),
    .xa_ready(xa_ready), .xa_data_rd(xa_data_rd), .xa_rd_valid(xa_rd_valid),
    .xa_rd_err(xa_rd_err), .wa_addr(wa_addr), .wa_data_wr(wa_data_wr),
    .wa_wr_s(wa_wr_s), .wa_rd_s(wa_rd_s), .wa_ready(wa_ready),
    .wa_data_rd(wa_data_rd), .wa_rd_valid(wa_rd_valid), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wreq_t;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] data;
  } rrsp_t;

  wreq_t wq[$];
  rrsp_t rq[$];
  wreq_t mon_w;
  rrsp_t mon_r;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int cnt_wr = 0;
  int cnt_rd = 0;
  int cnt_rv = 0;
  int last_wa_cyc = 0;
  int last_rd_cyc = 0;
  int rsp_delay = 1;
  logic [DW-1:0] rsp_data = '0;
  int rem = 0;
  bit pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: every W strobe and every X read return is matched against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wa_wr_s || wa_rd_s) begin
        check("wa_one_strobe", 32'(wa_wr_s & wa_rd_s), 0);
        if (wq.size() == 0) begin
          check("wa_unexpected", 1, 0);
        end else begin
          mon_w = wq.pop_front();
          check("wa_kind", 32'(wa_rd_s), 32'(mon_w.rd));
          check("wa_addr", 32'(wa_addr), 32'(mon_w.addr));
          check("wa_data", 32'(wa_data_wr), 32'(mon_w.data));
        end
        last_wa_cyc = cyc;
        if (wa_rd_s) begin
          cnt_rd++;
          last_rd_cyc = cyc;
        end else begin
          cnt_wr++;
        end
      end
      if (xa_rd_valid) begin
        cnt_rv++;
        if (rq.size() == 0) begin
          check("rv_unexpected", 1, 0);
        end else begin
          mon_r = rq.pop_front();
          check("rv_data", 32'(xa_data_rd), 32'(mon_r.data));
          check("rv_err", 32'(xa_rd_err), 32'(mon_r.err));
        end
      end else if (xa_rd_err) begin
        check("err_without_valid", 1, 0);
      end
    end
  end

  // W-side read responder: answers rsp_delay cycles after wa_rd_s; rsp_delay <= 0 never answers.
  always @(negedge clk) begin
    wa_rd_valid = 1'b0;
    wa_data_rd  = 16'hDEAD;
    if (pend) begin
      rem--;
      if (rem <= 0) begin
        wa_rd_valid = 1'b1;
        wa_data_rd  = rsp_data;
        pend = 1'b0;
      end
    end
    if (rst_n && wa_rd_s && rsp_delay > 0) begin
      pend = 1'b1;
      rem  = rsp_delay;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic w, input logic r, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output bit acc);
    tick();
    acc = xa_ready;
    xa_wr_s = w;
    xa_rd_s = r;
    xa_addr = a;
    xa_data_wr = d;
    if (acc && (w || r)) wq.push_back('{rd: (r & ~w), addr: a, data: d});
  endtask

  task automatic idle();
    tick();
    xa_wr_s = 1'b0;
    xa_rd_s = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int maxc, input string tag);
    for (int i = 0; i < maxc && (cnt_wr + cnt_rd) < target; i++) tick();
    if ((cnt_wr + cnt_rd) < target) check(tag, cnt_wr + cnt_rd, target);
  endtask

  task automatic wait_rv(input int maxc, input string tag);
    for (int i = 0; i < maxc && !xa_rd_valid; i++) tick();
    if (!xa_rd_valid) check(tag, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int nacc, b, bw, br, t0, nwr, first_c, last_c;

    // Reset state
    repeat (3) tick();
    check("rst_flags", {27'b0, xa_ready, xa_rd_valid, xa_rd_err, wa_wr_s, wa_rd_s}, 0);
    check("rst_wa_addr", 32'(wa_addr), 0);
    check("rst_xa_data", 32'(xa_data_rd), 0);
    check("rst_level", 32'(fifo_level), 0);
    rst_n = 1'b1;
    check("ready_before_edge", 32'(xa_ready), 0);
    tick();
    check("ready_after_rst", 32'(xa_ready), 1);

    // Single write latency
    b = cnt_wr + cnt_rd;
    send(1'b1, 1'b0, 16'h0010, 16'hBEEF, acc);
    t0 = cyc;
    idle();
    wait_strobes(b + 1, 10, "t1_no_strobe");
    check("t1_latency", last_wa_cyc - t0, 2);
    check("t1_level", 32'(fifo_level), 0);

    // Fill with wa_ready low, then drain
    wa_ready = 1'b0;
    b = cnt_wr + cnt_rd;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b0, 16'h0100 + 16'(i), 16'hC000 + 16'(i), acc);
      nacc += int'(acc);
    end
    idle();
    check("t2_accepted", nacc, 4);
    check("t2_ready_full", 32'(xa_ready), 0);
    check("t2_level_full", 32'(fifo_level), 4);
    check("t2_no_issue", cnt_wr + cnt_rd - b, 0);
    wa_ready = 1'b1;
    nwr = 0;
    first_c = 0;
    last_c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (wa_wr_s) begin
        if (nwr == 0) first_c = cyc;
        last_c = cyc;
        nwr++;
      end
    end
    check("t2_pulses", nwr, 4);
    check("t2_span", last_c - first_c, 3);
    check("t2_ready_back", 32'(xa_ready), 1);
    check("t2_level_empty", 32'(fifo_level), 0);

    // Write, read, write ordering with delayed read data
    rsp_delay = 2;
    rsp_data = 16'h1234;
    b = cnt_wr + cnt_rd;
    send(1'b1, 1'b0, 16'h0001, 16'hA001, acc);
    send(1'b0, 1'b1, 16'h0002, 16'h0000, acc);
    rq.push_back('{err: 1'b0, data: 16'h1234});
    send(1'b1, 1'b0, 16'h0003, 16'hA003, acc);
    idle();
    wait_rv(30, "t3_no_rv");
    check("t3_wr_held", cnt_wr + cnt_rd - b, 2);
    check("t3_rd_data", 32'(xa_data_rd), 32'h1234);
    check("t3_rd_err", 32'(xa_rd_err), 0);
    tick();
    check("t3_wr_after_rv", 32'(wa_wr_s), 1);
    check("t3_data_hold", 32'(xa_data_rd), 32'h1234);

    // Read round trip with one-cycle W response
    rsp_delay = 1;
    rsp_data = 16'hCAFE;
    send(1'b0, 1'b1, 16'h0030, 16'h0000, acc);
    rq.push_back('{err: 1'b0, data: 16'hCAFE});
    t0 = cyc;
    idle();
    wait_rv(20, "rt_no_rv");
    check("rt_latency", cyc - t0, 4);

    // Read timeout, following write issues next cycle
    rsp_delay = -1;
    send(1'b0, 1'b1, 16'h0040, 16'h0000, acc);
    rq.push_back('{err: 1'b1, data: 16'hFFFF});
    send(1'b1, 1'b0, 16'h0041, 16'h7777, acc);
    idle();
    wait_rv(TIMEOUT + 20, "t4_no_rv");
    check("t4_to_latency", cyc - last_rd_cyc, TIMEOUT);
    check("t4_err_data", 32'(xa_data_rd), 32'hFFFF);
    check("t4_err_flag", 32'(xa_rd_err), 1);
    tick();
    check("t4_next_issue", 32'(wa_wr_s), 1);

    // Simultaneous write and read strobes act as one write
    rsp_delay = 1;
    bw = cnt_wr;
    br = cnt_rd;
    send(1'b1, 1'b1, 16'h0020, 16'h5555, acc);
    idle();
    repeat (5) tick();
    check("t5_writes", cnt_wr - bw, 1);
    check("t5_reads", cnt_rd - br, 0);

    // Reset while waiting on a read with two entries queued
    rsp_delay = -1;
    send(1'b0, 1'b1, 16'h0060, 16'h0000, acc);
    send(1'b1, 1'b0, 16'h0061, 16'h6161, acc);
    send(1'b1, 1'b0, 16'h0062, 16'h6262, acc);
    idle();
    check("t6_level_queued", 32'(fifo_level), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_flags", {27'b0, xa_ready, xa_rd_valid, xa_rd_err, wa_wr_s, wa_rd_s}, 0);
    check("t6_wa_addr", 32'(wa_addr), 0);
    check("t6_level", 32'(fifo_level), 0);
    wq.delete();
    rq.delete();
    tick();
    tick();
    rst_n = 1'b1;
    b = cnt_rv;
    bw = cnt_wr + cnt_rd;
    repeat (30) tick();
    check("t6_no_rv", cnt_rv - b, 0);
    check("t6_no_strobe", cnt_wr + cnt_rd - bw, 0);
    check("t6_ready", 32'(xa_ready), 1);

    check("end_wq_empty", wq.size(), 0);
    check("end_rq_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
